// File: rtl/qam_pkg.sv
// rtl/qam_pkg.sv - shared modulation constants, PRBS-15 taps and step helper
package qam_pkg;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_16QAM = 1'b1;

  // Fibonacci PRBS-15, x^15 + x^14 + 1: feedback bit = s[14] ^ s[13]
  localparam int PRBS15_TAP_A    = 14;
  localparam int PRBS15_TAP_B    = 13;
  // Largest advance ever requested in one symbol (16QAM)
  localparam int PRBS15_MAX_STEP = 4;

  typedef logic [14:0] prbs15_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } src_state_t;

  // State after k shifts; loop bound is fixed so it unrolls to plain XOR logic
  function automatic prbs15_t prbs15_step(input prbs15_t s, input int unsigned k);
    prbs15_t r;
    r = s;
    for (int unsigned i = 0; i < PRBS15_MAX_STEP; i++) begin
      if (i < k) r = {r[13:0], r[PRBS15_TAP_A] ^ r[PRBS15_TAP_B]};
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_payload_source_if.sv
// rtl/prbs_payload_source_if.sv - payload source <-> pilot inserter signal bundle
interface prbs_payload_source_if #(
  parameter int CNT_WIDTH = 11
);
  logic                 mod_type;
  logic                 data_req;
  logic                 restart;
  logic [3:0]           data_out;
  logic                 data_valid;
  logic                 frame_done;
  logic [CNT_WIDTH-1:0] sym_count;

  modport master (
    output mod_type, data_req, restart,
    input  data_out, data_valid, frame_done, sym_count
  );

  modport slave (
    input  mod_type, data_req, restart,
    output data_out, data_valid, frame_done, sym_count
  );
endinterface

// File: rtl/lfsr_prbs15.sv
// rtl/lfsr_prbs15.sv - PRBS-15 state register with 2/4-step advance and look-ahead taps
module lfsr_prbs15
  import qam_pkg::*;
#(
  parameter prbs15_t SEED = 15'h7FFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  input  logic       mod_type,
  output logic [3:0] look_ahead
);

  prbs15_t state_q;

  // Reseed on reset/load, otherwise advance by the bits one symbol consumes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= prbs15_step(state_q, (mod_type == MOD_16QAM) ? 32'd4 : 32'd2);
    end
  end

  // The next four output bits, oldest first in the MSB
  assign look_ahead = state_q[14:11];

endmodule

// File: rtl/prbs_payload_source.sv
// rtl/prbs_payload_source.sv - PRBS-15 payload symbol source with per-frame symbol count
module prbs_payload_source
  import qam_pkg::*;
#(
  parameter prbs15_t LFSR_SEED   = 15'h7FFF,
  parameter int      PAYLOAD_LEN = 1024,
  parameter int      CNT_WIDTH   = 11
) (
  input  logic                 clk_symbol,
  input  logic                 rst_n,
  prbs_payload_source_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LEN_LIMIT   = CNT_WIDTH'(PAYLOAD_LEN);
  // An empty frame has nothing to emit, so it starts out finished
  localparam src_state_t           START_STATE = (PAYLOAD_LEN == 0) ? ST_DONE : ST_RUN;

  src_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 consume;
  logic [3:0]           look_ahead;

  lfsr_prbs15 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk_symbol),
    .rst_n      (rst_n),
    .load       (bus.restart),
    .advance    (consume),
    .mod_type   (bus.mod_type),
    .look_ahead (look_ahead)
  );

  // FSM state and symbol counter registers
  always_ff @(posedge clk_symbol or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, consume decision and symbol decode; restart wins over a request
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    consume        = 1'b0;
    bus.data_out   = 4'b0000;
    bus.data_valid = (state_q == ST_RUN);
    bus.frame_done = (state_q == ST_DONE);
    bus.sym_count  = cnt_q;

    if (bus.restart) begin
      state_d = START_STATE;
      cnt_d   = '0;
    end else if (state_q == ST_RUN && bus.data_req) begin
      consume = 1'b1;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_d == LEN_LIMIT) state_d = ST_DONE;
    end

    if (state_q == ST_RUN) begin
      bus.data_out = (bus.mod_type == MOD_QPSK) ? {2'b00, look_ahead[3:2]} : look_ahead;
    end
  end

endmodule
